// File: rtl/dict_hdr.sv
// dict_hdr: scans a name from the TIB and appends a link/length/name header at here
module dict_hdr #(
  parameter int ASZ = 16,
  parameter int DSZ = 8,
  parameter logic [ASZ-1:0] DICT = 16'h10,
  parameter int NMAX = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] ai,
  output logic           bsy,
  output logic           done,
  output logic           err,
  output logic [ASZ-1:0] lfa,
  output logic [ASZ-1:0] here,
  output logic           mem_re,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_a,
  output logic [DSZ-1:0] mem_d,
  input  logic [DSZ-1:0] mem_q
);
  localparam int NW = $clog2(NMAX + 1);
  localparam logic [NW-1:0] NMX = NW'(NMAX);
  typedef enum logic [2:0] {IDLE, RD, CHK, LEN, LFL, LFH, DONE, ERR} st_t;
  st_t st_q, st_d;
  logic [ASZ-1:0] src_q, src_d, lfa_q, lfa_d, here_q, here_d;
  logic [NW-1:0] n_q, n_d;
  logic delim, go, wr_ch;
  assign delim = (mem_q == '0) || (mem_q == DSZ'('h20));
  assign go = (st_q == IDLE) && start;
  assign wr_ch = (st_q == CHK) && !delim && (n_q != NMX);
  assign lfa = lfa_q;
  assign here = here_q;
  // state register; reset also cancels any build in flight
  always_ff @(posedge clk)
    if (rst) st_q <= IDLE;
    else st_q <= st_d;
  // datapath registers: TIB pointer, name length and dictionary pointers
  always_ff @(posedge clk)
    if (rst) begin
      src_q <= '0;
      n_q <= '0;
      lfa_q <= '1;
      here_q <= DICT;
    end else begin
      src_q <= src_d;
      n_q <= n_d;
      lfa_q <= lfa_d;
      here_q <= here_d;
    end
  // next state; a delimiter ends the name, an empty or overlong name aborts
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: st_d = start ? RD : IDLE;
      RD:   st_d = CHK;
      CHK:  st_d = delim ? (n_q == '0 ? ERR : LEN) : (n_q == NMX ? ERR : RD);
      LEN:  st_d = LFL;
      LFL:  st_d = LFH;
      LFH:  st_d = DONE;
      default: st_d = IDLE;
    endcase
  end
  // datapath next values; pointers commit only once the link high byte is written
  always_comb begin
    src_d = go ? ai : wr_ch ? src_q + 1'b1 : src_q;
    n_d = go ? '0 : wr_ch ? n_q + 1'b1 : n_q;
    lfa_d = (st_q == LFH) ? here_q : lfa_q;
    here_d = (st_q == LFH) ? here_q + ASZ'(3) + ASZ'(n_q) : here_q;
  end
  // outputs decoded from the state register; name bytes pass straight from mem_q
  always_comb begin
    bsy = st_q inside {RD, CHK, LEN, LFL, LFH};
    done = st_q == DONE;
    err = st_q == ERR;
    mem_re = st_q == RD;
    mem_we = wr_ch || (st_q inside {LEN, LFL, LFH});
    mem_a = (st_q == RD)  ? src_q :
            (st_q == CHK) ? here_q + ASZ'(3) + ASZ'(n_q) :
            (st_q == LEN) ? here_q + ASZ'(2) :
            (st_q == LFL) ? here_q :
            (st_q == LFH) ? here_q + ASZ'(1) : '0;
    mem_d = (st_q == CHK) ? mem_q :
            (st_q == LEN) ? DSZ'(n_q) :
            (st_q == LFL) ? DSZ'(lfa_q[7:0]) :
            (st_q == LFH) ? DSZ'(lfa_q[15:8]) : '0;
  end
endmodule

// File: tb/tb_dict_hdr.sv
// tb_dict_hdr: randomized scoreboard bench for dict_hdr with a behavioural pool and header model
module tb_dict_hdr;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] ai = '0;
  logic bsy, done, err, mem_re, mem_we;
  logic [15:0] lfa, here, mem_a;
  logic [7:0] mem_d, mem_q = '0;
  logic [7:0] pool [0:65535];
  int cyc = 0, we_cnt = 0, vecs = 0, miscmp = 0;
  logic [15:0] ref_lfa = 16'hFFFF, ref_here = 16'h10;
  typedef struct { bit e; logic [15:0] lfa; logic [15:0] here; int cyc; } exp_t;
  exp_t q[$];
  exp_t mx;

  dict_hdr dut (
    .clk(clk), .rst(rst), .start(start), .ai(ai), .bsy(bsy), .done(done), .err(err),
    .lfa(lfa), .here(here), .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pool: one byte port, read data one cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) begin
      pool[mem_a] = mem_d;
      we_cnt = we_cnt + 1;
    end
    if (mem_re) mem_q <= pool[mem_a];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // monitor: pop the expected completion whenever done or err is presented
  always @(negedge clk) begin
    if (mem_re && mem_we) begin
      vecs++;
      miscmp++;
      $display("FAIL strobe_excl: mem_re and mem_we both high at cycle %0d", cyc);
    end
    if (done || err) begin
      if (q.size() == 0) begin
        vecs++;
        miscmp++;
        $display("FAIL unexpected_pulse: done=%b err=%b with nothing pending at cycle %0d", done, err, cyc);
      end else begin
        mx = q.pop_front();
        chk("kind_err", {31'd0, err}, {31'd0, mx.e});
        chk("kind_done", {31'd0, done}, {31'd0, !mx.e});
        chk("lfa", {16'd0, lfa}, {16'd0, mx.lfa});
        chk("here", {16'd0, here}, {16'd0, mx.here});
        chk("latency", cyc, mx.cyc);
      end
    end
  end

  task automatic load(input logic [15:0] a, input string s, input logic [7:0] t);
    for (int i = 0; i < s.len(); i++) pool[16'(a + i)] = s[i];
    pool[16'(a + s.len())] = t;
  endtask

  // reference: name = leading non-delimiter bytes; 0 or >NMAX aborts, else header appended
  task automatic run(input logic [15:0] a, input bit noise);
    int n, lat, w0, wexp;
    bit e;
    exp_t x;
    logic [7:0] hb[$];
    logic [15:0] h0;
    n = 0;
    while (n < 32 && pool[16'(a + n)] != 8'h00 && pool[16'(a + n)] != 8'h20) n++;
    e = (n == 0) || (n == 32);
    lat = (n == 0) ? 3 : (n == 32) ? 65 : 2 * n + 6;
    wexp = (n == 0) ? 0 : (n == 32) ? 31 : n + 3;
    hb = {ref_lfa[7:0], ref_lfa[15:8], 8'(n)};
    for (int i = 0; i < n && i < 31; i++) hb.push_back(pool[16'(a + i)]);
    h0 = ref_here;
    if (!e) begin
      ref_lfa = ref_here;
      ref_here = 16'(ref_here + 3 + n);
    end
    @(negedge clk);
    start = 1;
    ai = a;
    x.e = e; x.lfa = ref_lfa; x.here = ref_here; x.cyc = cyc + lat;
    q.push_back(x);
    w0 = we_cnt;
    @(negedge clk);
    start = 0;
    if (noise) begin
      start = 1;
      ai = 16'($urandom);
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 120 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      vecs++;
      miscmp++;
      $display("FAIL timeout: build at %0h never completed", a);
      q.delete();
    end
    repeat (3) @(negedge clk);
    chk("write_count", we_cnt - w0, wexp);
    chk("lfa_now", {16'd0, lfa}, {16'd0, ref_lfa});
    chk("here_now", {16'd0, here}, {16'd0, ref_here});
    if (!e)
      for (int i = 0; i < hb.size(); i++) chk("hdr_byte", {24'd0, pool[16'(h0 + i)]}, {24'd0, hb[i]});
  endtask

  initial begin
    string s;
    int n;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) pool[i] = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_bsy", {31'd0, bsy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_re", {31'd0, mem_re}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_a", {16'd0, mem_a}, 0);
    chk("rst_d", {24'd0, mem_d}, 0);
    chk("rst_lfa", {16'd0, lfa}, 32'hFFFF);
    chk("rst_here", {16'd0, here}, 32'h10);
    rst = 0;
    load(16'h0, "abcd", 8'h00);
    run(16'h0, 0);
    chk("abcd_lfa", {16'd0, lfa}, 32'h10);
    chk("abcd_here", {16'd0, here}, 32'h17);
    load(16'h5, "efgh", 8'h20);
    run(16'h5, 0);
    chk("efgh_lfa", {16'd0, lfa}, 32'h17);
    chk("efgh_here", {16'd0, here}, 32'h1E);
    load(16'h0A, "ijkl", 8'h00);
    run(16'h0A, 0);
    load(16'h100, "mnop", 8'h20);
    run(16'h100, 0);
    chk("four_lfa", {16'd0, lfa}, 32'h25);
    chk("four_here", {16'd0, here}, 32'h2C);
    load(16'h110, "", 8'h20);
    run(16'h110, 0);
    load(16'h118, "", 8'h00);
    run(16'h118, 0);
    s = "";
    for (int i = 0; i < 32; i++) s = {s, "x"};
    load(16'h120, s, 8'h00);
    run(16'h120, 0);
    load(16'h150, "qrs", 8'h00);
    run(16'h150, 0);
    load(16'h160, "tuvwxyz", 8'h20);
    run(16'h160, 1);
    load(16'h200, "reset", 8'h00);
    @(negedge clk);
    start = 1;
    ai = 16'h200;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ref_lfa = 16'hFFFF;
    ref_here = 16'h10;
    chk("abort_bsy", {31'd0, bsy}, 0);
    chk("abort_lfa", {16'd0, lfa}, 32'hFFFF);
    chk("abort_here", {16'd0, here}, 32'h10);
    run(16'h200, 0);
    for (int r = 0; r < 24; r++) begin
      a = 16'(16'h8000 + r * 64);
      n = $urandom % 40;
      if (n > 33) n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) pool[16'(a + i)] = 8'($urandom_range(33, 126));
      pool[16'(a + n)] = ($urandom % 2) ? 8'h20 : 8'h00;
      run(a, 1'($urandom % 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule

// File: doc/dict_hdr.md
# dict_hdr

Dictionary header builder for the ForthSuper memory pool. On a `start` strobe it scans a word name out of the terminal input buffer (TIB) through the pool's single byte port. It then appends a complete header at `here`: link field, length byte and name bytes. Finally it commits the new `lfa` and `here`. It sits between the outer interpreter (requester) and the pool, and owns the dictionary pointers.

## Interface
- `ASZ`, 16: address width. Link fields are stored as 2 bytes, little-endian.
- `DSZ`, 8: data width (bytes).
- `DICT`, 'h10: reset value of `here`.
- `NMAX`, 31: maximum name length in bytes.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a header build. Sampled only when `bsy`=0.
- `ai` in ASZ: TIB address of the first name character. Latched on an accepted `start`.
- `bsy` out 1: build in progress.
- `done` out 1: one-cycle pulse when a header is committed.
- `err` out 1: one-cycle pulse when a build is aborted.
- `lfa` out ASZ: address of the latest header (link of the last word).
- `here` out ASZ: next free dictionary byte. This is also the code-field address of the word just committed.
- `mem_re` out 1: pool read strobe.
- `mem_we` out 1: pool write strobe.
- `mem_a` out ASZ: pool address.
- `mem_d` out DSZ: pool write data.
- `mem_q` in DSZ: pool read data, valid exactly 1 cycle after `mem_re`.

## Operation
- Registers:
  - `src`: TIB pointer.
  - `n`: name length, 0..NMAX.
  - `lfa`, `here`.
  - `state`: IDLE, RD, CHK, LEN, LFL, LFH, DONE, ERR.
- IDLE:
  - `bsy`=0, strobes 0.
  - If `start`: `src`<=`ai`, `n`<=0, go to RD.
- RD: `mem_re`=1, `mem_a`=`src`. Go to CHK.
- CHK (`mem_q` valid), checked in this order:
  - If `mem_q` is 'h00 or 'h20 (delimiter): go to ERR if `n`==0, else go to LEN.
  - Else if `n`==NMAX: go to ERR.
  - Else write the character: `mem_we`=1, `mem_a`=`here`+3+`n`, `mem_d`=`mem_q`. Then `n`++, `src`++, go to RD.
- LEN: write `n` to `here`+2.
- LFL: write `lfa`[7:0] to `here`.
- LFH: write `lfa`[15:8] to `here`+1. Then `lfa`<=`here`, `here`<=`here`+3+`n`. Go to DONE.
- DONE: `done`=1, `bsy`=0. Go to IDLE.
- ERR: `err`=1, `bsy`=0. Go to IDLE. `lfa`, `here` and `n` are not updated. Name bytes already written above `here` are garbage and will be overwritten by the next build.
- `mem_re` and `mem_we` are never high in the same cycle. While either strobe is 0, `mem_a`/`mem_d` are don't-care.
- Address arithmetic is modulo 2^ASZ. No overflow detection; the caller keeps `here` below the top of the pool.
- Leading delimiters are not skipped. The requester points `ai` at the first non-blank character.

## Timing
- Reset values:
  - State IDLE.
  - `bsy`=`done`=`err`=`mem_re`=`mem_we`=0.
  - `mem_a`=0, `mem_d`=0.
  - `lfa`='hFFFF (all ones, the end-of-chain marker).
  - `here`=DICT.
- Outputs are registered; state decodes drive the strobes and address/data.
- Cycle numbering: `start` sampled in IDLE at cycle 0.
  - `bsy`=1 in cycles 1..2n+5.
  - RD/CHK pairs occupy cycles 1..2n+2.
  - LEN, LFL, LFH occupy cycles 2n+3..2n+5.
  - `done`=1 in cycle 2n+6, with `bsy`=0.
  - Updated `lfa`/`here` are visible from cycle 2n+6.
- Empty-name error: `err` at cycle 3. Overlong-name error: `err` at cycle 2·NMAX+3.
- `start` while `bsy`=1 is ignored, not queued. `start` in the DONE/ERR cycle is also ignored. `start` is first accepted again the cycle after `done` or `err`.
- `rst` mid-build aborts immediately:
  - Returns to IDLE.
  - Restores `lfa`/`here` to their reset values.
  - No `done`/`err` pulse.

## Test plan
- Reset, then TIB = "abcd",'h00 at 0, `start` with `ai`=0:
  - Pool 'h10..'h16 = FF FF 04 61 62 63 64.
  - `done` at cycle 14, `lfa`='h10, `here`='h17.
- Continue with TIB "efgh " at 5, `start` with `ai`=5:
  - Pool 'h17..'h1D = 10 00 04 65 66 67 68.
  - `lfa`='h17, `here`='h1E.
  - Build "ijkl" and "mnop" the same way: final `lfa`='h25, `here`='h2C.
- Name starting with 'h20 or 'h00:
  - `err` at cycle 3, no `mem_we` ever asserted.
  - `lfa`/`here` unchanged.
- 32 non-blank characters:
  - 31 name writes, then `err` at cycle 65.
  - `lfa`/`here` unchanged; a following valid build overwrites from the old `here`.
- `start` pulsed during `bsy`: no effect, exactly one `done` is seen.
- `rst` in cycle 5 of a build:
  - Next cycle: `bsy`=0, `lfa`='hFFFF, `here`='h10.
  - A fresh build then completes normally.
